serpent_sbox_unit: RTL
======================

// Module: serpent_sbox_unit
// PURPOSE
// - Multi-cycle Serpent substitution unit on a 128-bit bitsliced block: 4 x 32-bit words, column i = nibble {w0[i],w1[i],w2[i],w3[i]}.
// - w0 = data[31:0] is the nibble MSB; w3 = data[127:96] is the LSB.
// - Applies forward S-box S0..S7 or its inverse, LANES columns per cycle, with valid/ready handshakes on both sides.
// - Sits between the round-key XOR and the linear transform in the cipher/decipher round datapath.
// PARAMETERS
// - LANES  default 8  columns substituted per cycle; legal 1,2,4,8,16,32; NCYC = 32/LANES processing cycles per block.
// PORTS
// - clk        in   1    clock, all flops on rising edge.
// - rst        in   1    asynchronous, active-high reset; one clock.
// - in_valid   in   1    upstream has a block.
// - in_ready   out  1    unit can accept; transfer when in_valid && in_ready.
// - in_data    in   128  bitsliced block.
// - in_sel     in   3    S-box index 0..7, sampled on transfer.
// - in_inv     in   1    1 = inverse S-box, sampled on transfer.
// - out_valid  out  1    out_data holds a finished block.
// - out_ready  in   1    downstream accepts; transfer when out_valid && out_ready.
// - out_data   out  128  substituted block, same bit layout as in_data.
// - busy       out  1    high in BUSY state.
// BEHAVIOUR
// - States IDLE, BUSY, DONE. Reset: state=IDLE, col=0, work reg=0, sel/inv regs=0, out_valid=0, busy=0, in_ready=1 (combinational from IDLE).
// - in_ready = (state==IDLE) || (state==DONE && out_ready); accept = in_valid && in_ready.
// - IDLE: on accept, latch in_data->work, in_sel, in_inv; col<=0; ->BUSY.
// - BUSY: replace columns col*LANES .. col*LANES+LANES-1 of work in place via table[sel][inv].
//   - Other columns unchanged. col<=col+1.
//   - When col==NCYC-1: col<=0, ->DONE.
//   - in_data/in_sel changes during BUSY have no effect.
// - DONE: out_valid=1, out_data=work, stable until transfer.
//   - transfer with accept same cycle -> latch new block, ->BUSY (back-to-back).
//   - transfer without accept -> IDLE.
//   - no transfer -> hold.
// - Latency: accept on edge k -> out_valid high after edge k+NCYC; throughput one block per NCYC+1 cycles when back-to-back.
// - LANES=32: BUSY lasts exactly one cycle. col width = max(1,$clog2(NCYC)), wraps only via explicit clear, never overflows.
// - out_valid=0 forces nothing on out_data; out_data always equals work reg.
// - rst mid-BUSY or mid-DONE: block discarded, return to reset values; no output produced.
// - Forward tables (input 0..15):
//   - S0 3 8 15 1 10 6 5 11 14 13 4 2 7 0 9 12
//   - S1 15 12 2 7 9 0 5 10 1 11 14 8 6 13 3 4
//   - S2 8 6 7 9 3 12 10 15 13 1 14 4 0 11 5 2
//   - S3 0 15 11 8 12 9 6 3 13 1 2 4 10 7 5 14
//   - S4 1 15 8 3 12 0 11 6 2 5 4 10 9 14 7 13
//   - S5 15 5 2 11 4 10 9 12 0 3 14 8 13 6 7 1
//   - S6 7 2 12 5 8 4 6 11 14 9 1 15 13 3 10 0
//   - S7 1 13 15 0 14 8 2 11 7 4 12 10 9 3 5 6
// - Inverse table = exact inverse permutation of each forward table: INV[s][S[s][x]] = x.
// STRUCTURE
// - Package serpent_pkg: SBOX_FWD[8][16] and SBOX_INV[8][16] 4-bit constant arrays, inverse computed by function at elaboration; state enum type.
// - Sub-module serpent_sbox_nibble: combinational 4-bit in, sel[2:0], inv -> 4-bit out. Instantiate LANES copies via generate.
// - Top: FSM, col counter, 128-bit work reg with column muxing.
// TESTING
// - in_data=0, sel=0, inv=0, LANES=8 -> out_valid after exactly 4 cycles; out_data=128'hFFFFFFFF_FFFFFFFF_00000000_00000000.
// - in_data=all ones, sel=7, inv=0 -> out_data=128'h00000000_FFFFFFFF_FFFFFFFF_00000000.
// - Round trip all s, 1000 random blocks: fwd result fed back with inv=1 -> original block, for LANES in {1,8,32}.
// - out_ready held 0 for 10 cycles in DONE -> out_data/out_valid stable, in_ready=0.
//   - Then out_ready=1 with in_valid=1 -> new block accepted the same cycle, busy next cycle.
// - rst pulse in middle of BUSY -> out_valid=0, in_ready=1, busy=0 immediately (async); the next block completes correctly.
// - Change in_data/in_sel during BUSY -> result matches originally latched values.

Source files
------------

// File: rtl/serpent_pkg.sv
// Serpent S-box constants shared by the substitution unit.
// Forward tables are written one row per S-box (entry 0 in the top nibble);
// inverse tables are derived from them while elaborating.
package serpent_pkg;

    localparam int NUM_SBOX = 8;

    // [sbox][input] -> 4-bit output
    typedef logic [NUM_SBOX-1:0][15:0][3:0] sbox_tbl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Row s holds S_s(0) .. S_s(15), first entry in bits [63:60].
    localparam logic [NUM_SBOX-1:0][63:0] SBOX_ROWS = {
        64'h1DF0E82B74CA9356,   // S7
        64'h72C5846BE91FD3A0,   // S6
        64'hF52B4A9C03E8D671,   // S5
        64'h1F83C0B6254A9E7D,   // S4
        64'h0FB8C963D124A75E,   // S3
        64'h86793CAFD1E40B52,   // S2
        64'hFC27905A1BE86D34,   // S1
        64'h38F1A65BED42709C    // S0
    };

    function automatic sbox_tbl_t build_fwd(input logic [NUM_SBOX-1:0][63:0] rows);
        sbox_tbl_t   t;
        logic [63:0] row;
        t = '0;
        for (int s = 0; s < NUM_SBOX; s++) begin
            row = rows[3'(s)];
            for (int x = 0; x < 16; x++) begin
                t[3'(s)][4'(x)] = row[63:60];
                row = row << 4;
            end
        end
        return t;
    endfunction

    // Each forward table is a permutation, so scattering x to position S(x)
    // fills every inverse entry exactly once.
    function automatic sbox_tbl_t build_inv(input sbox_tbl_t f);
        sbox_tbl_t t;
        t = '0;
        for (int s = 0; s < NUM_SBOX; s++) begin
            for (int x = 0; x < 16; x++) begin
                t[3'(s)][f[3'(s)][4'(x)]] = 4'(x);
            end
        end
        return t;
    endfunction

    localparam sbox_tbl_t SBOX_FWD = build_fwd(SBOX_ROWS);
    localparam sbox_tbl_t SBOX_INV = build_inv(SBOX_FWD);

endpackage

// File: rtl/serpent_sbox_unit_if.sv
// Handshake bundle for the S-box unit: upstream block input with S-box
// selection, downstream finished block, and a busy indicator.
interface serpent_sbox_unit_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [2:0]   in_sel;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    // Producer/consumer side (round datapath or testbench)
    modport master (
        output in_valid, in_data, in_sel, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Substitution unit side
    modport slave (
        input  in_valid, in_data, in_sel, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/serpent_sbox_nibble.sv
// One Serpent S-box lookup on a single 4-bit column, forward or inverse.
module serpent_sbox_nibble
    import serpent_pkg::*;
(
    input  logic [3:0] din,
    input  logic [2:0] sel,
    input  logic       inv,
    output logic [3:0] dout
);

    assign dout = inv ? SBOX_INV[sel][din] : SBOX_FWD[sel][din];

endmodule

// File: rtl/serpent_sbox_unit.sv
// Multi-cycle Serpent substitution on a bitsliced 128-bit block.
// Column i is the nibble {w0[i],w1[i],w2[i],w3[i]} with w0 = data[31:0]
// as MSB. LANES columns are rewritten in place each BUSY cycle.
module serpent_sbox_unit
    import serpent_pkg::*;
#(
    parameter int LANES = 8
)
(
    input  logic          clk,
    input  logic          rst,
    serpent_sbox_unit_if.slave sif
);

    localparam int NCYC = 32 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [127:0]     work_q, work_d;
    logic [2:0]       sel_q, sel_d;
    logic             inv_q, inv_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             last_col;
    logic [4:0]       col_base;
    logic [LANES-1:0][3:0] nib_in;
    logic [LANES-1:0][3:0] nib_out;

    // A finished block can be handed off and replaced in the same cycle.
    assign sif.in_ready  = (state_q == ST_IDLE) ||
                           ((state_q == ST_DONE) && sif.out_ready);
    assign accept        = sif.in_valid && sif.in_ready;
    assign last_col      = (col_q == CW'(NCYC - 1));
    assign col_base      = 5'(int'(col_q) * LANES);

    assign sif.out_valid = out_valid_q;
    assign sif.out_data  = work_q;
    assign sif.busy      = busy_q;

    // Gather the current group of columns out of the four bitslice words.
    always_comb begin
        logic [4:0] c;
        c      = '0;
        nib_in = '0;
        for (int l = 0; l < LANES; l++) begin
            c         = col_base + 5'(l);
            nib_in[l] = {work_q[{2'd0, c}], work_q[{2'd1, c}],
                         work_q[{2'd2, c}], work_q[{2'd3, c}]};
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serpent_sbox_nibble u_nib (
            .din  (nib_in[g]),
            .sel  (sel_q),
            .inv  (inv_q),
            .dout (nib_out[g])
        );
    end

    // Next-state: FSM transitions, column sweep, in-place write-back, load.
    always_comb begin
        logic [4:0] c;
        c       = '0;
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        sel_d   = sel_q;
        inv_d   = inv_q;

        case (state_q)
            ST_IDLE: ;
            ST_BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    c                  = col_base + 5'(l);
                    work_d[{2'd0, c}]  = nib_out[l][3];
                    work_d[{2'd1, c}]  = nib_out[l][2];
                    work_d[{2'd2, c}]  = nib_out[l][1];
                    work_d[{2'd3, c}]  = nib_out[l][0];
                end
                if (last_col) begin
                    col_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    col_d   = col_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (sif.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // accept is never true in BUSY, so this cannot clash with write-back.
        if (accept) begin
            work_d  = sif.in_data;
            sel_d   = sif.in_sel;
            inv_d   = sif.in_inv;
            col_d   = '0;
            state_d = ST_BUSY;
        end

        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_BUSY);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            work_q      <= '0;
            sel_q       <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            work_q      <= work_d;
            sel_q       <= sel_d;
            inv_q       <= inv_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule
